// File: rtl/filt_buf_ctrl_pkg.sv
// rtl/filt_buf_ctrl_pkg.sv - shared constants and state encoding for the 4x4 filter buffer sequencer
package filt_buf_ctrl_pkg;

   localparam int DEPTH  = 16;
   localparam int WBYTES = 4;
   localparam int NWORDS = 4;
   localparam int ADDR_W = 4;
   localparam int PASS_W = 8;
   localparam int DATA_W = 32;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/filt_buf_ctrl_if.sv
// rtl/filt_buf_ctrl_if.sv - load stream, buffer port and byte stream signals of the filter sequencer
interface filt_buf_ctrl_if;
   import filt_buf_ctrl_pkg::*;

   logic  in_valid;
   logic  in_ready;
   word_t in_data;
   logic  buf_wr_en;
   addr_t buf_wr_addr;
   word_t buf_wr_data;
   addr_t buf_rd_addr;
   logic  out_valid;
   logic  out_ready;
   logic  out_last;

   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_addr, out_valid, out_last
   );

   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_addr, out_valid, out_last
   );

endinterface

// File: rtl/buf4x4_f.sv
// rtl/buf4x4_f.sv - 16-byte filter buffer, 32-bit word writes, combinational byte reads
module buf4x4_f
   import filt_buf_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       wr_en_i,
   input  addr_t      wr_addr_i,
   input  word_t      wr_data_i,
   input  addr_t      rd_addr_i,
   output logic [7:0] rd_data_o
);

   logic [7:0] mem_q [DEPTH];

   // byte0 of a word sits in the top lane and lands at the lowest address
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i]          <= wr_data_i[31:24];
         mem_q[wr_addr_i + 4'd1]   <= wr_data_i[23:16];
         mem_q[wr_addr_i + 4'd2]   <= wr_data_i[15:8];
         mem_q[wr_addr_i + 4'd3]   <= wr_data_i[7:0];
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/filt_buf_ctrl.sv
// rtl/filt_buf_ctrl.sv - loads one 4x4 filter as four words, then replays its bytes num_pass times
module filt_buf_ctrl
   import filt_buf_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [PASS_W-1:0] num_pass_i,
   filt_buf_ctrl_if.master   bus,
   output logic              busy_o,
   output logic              done_o
);

   localparam addr_t LAST_WR   = addr_t'((NWORDS - 1) * WBYTES);
   localparam addr_t LAST_BYTE = addr_t'(DEPTH - 1);
   localparam addr_t WSTEP     = addr_t'(WBYTES);

   logic [1:0]        state_q, state_d;
   addr_t             wr_ptr_q, wr_ptr_d;
   addr_t             rd_ptr_q, rd_ptr_d;
   logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [PASS_W-1:0] num_pass_q, num_pass_d;
   logic              in_load, in_stream, wr_fire, rd_fire, last_byte;

   assign in_load   = (state_q == ST_LOAD);
   assign in_stream = (state_q == ST_STREAM);
   assign last_byte = (rd_ptr_q == LAST_BYTE);
   assign wr_fire   = bus.in_valid & in_load;
   assign rd_fire   = bus.out_ready & in_stream;

   assign bus.in_ready    = in_load;
   assign bus.buf_wr_en   = wr_fire;
   assign bus.buf_wr_addr = wr_ptr_q;
   assign bus.buf_wr_data = in_load ? bus.in_data : '0;
   assign bus.buf_rd_addr = rd_ptr_q;
   assign bus.out_valid   = in_stream;
   assign bus.out_last    = in_stream & last_byte;
   assign busy_o          = (state_q != ST_IDLE);
   assign done_o          = (state_q == ST_DONE);

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pass_cnt_d = pass_cnt_q;
      num_pass_d = num_pass_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               num_pass_d = num_pass_i;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               pass_cnt_d = '0;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (wr_fire) begin
               wr_ptr_d = wr_ptr_q + WSTEP;
               if (wr_ptr_q == LAST_WR) begin
                  state_d = (num_pass_q == '0) ? ST_DONE : ST_STREAM;
               end
            end
         end
         ST_STREAM: begin
            // rd_ptr wraps to 0 naturally after the last byte, so passes run gap-free
            if (rd_fire) begin
               rd_ptr_d = rd_ptr_q + 4'd1;
               if (last_byte) begin
                  pass_cnt_d = pass_cnt_q + PASS_W'(1);
                  if (pass_cnt_q == num_pass_q - PASS_W'(1)) begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pass_cnt_q <= '0;
         num_pass_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pass_cnt_q <= pass_cnt_d;
         num_pass_q <= num_pass_d;
      end
   end

endmodule

// File: tb/tb_filt_buf_ctrl.sv
// tb/tb_filt_buf_ctrl.sv - directed self-checking bench for filt_buf_ctrl with buf4x4_f attached
module tb_filt_buf_ctrl;
   import filt_buf_ctrl_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_i;
   logic [PASS_W-1:0] num_pass_i;
   logic              busy_o, done_o;
   logic [7:0]        rd_data;

   int errors = 0;
   int checks = 0;

   word_t      words [4];
   logic [7:0] got [$];
   int n_last, last_bad, stall_bad, done_cnt, done_lat, wr_bad, timeout, gap;
   int first_acc, last_acc;

   filt_buf_ctrl_if bus ();

   filt_buf_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .num_pass_i (num_pass_i),
      .bus        (bus),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   buf4x4_f ubuf (
      .clk       (clk),
      .wr_en_i   (bus.buf_wr_en),
      .wr_addr_i (bus.buf_wr_addr),
      .wr_data_i (bus.buf_wr_data),
      .rd_addr_i (bus.buf_rd_addr),
      .rd_data_o (rd_data)
   );

   always #5 clk = ~clk;

   function automatic int seq_errors(input int np);
      int n = 0;
      if (got.size() != 16 * np) return 999;
      for (int i = 0; i < got.size(); i++)
         if (got[i] !== 8'(i % 16)) n++;
      return n;
   endfunction

   task automatic start_job(input int np);
      @(negedge clk);
      start_i    = 1'b1;
      num_pass_i = 8'(np);
      @(negedge clk);
      start_i    = 1'b0;
   endtask

   task automatic load_words(input bit toggle);
      int idx = 0;
      bit v   = 1'b1;
      wr_bad  = 0;
      timeout = 0;
      for (int cyc = 0; cyc < 100 && idx < 4; cyc++) begin
         bus.in_valid = toggle ? v : 1'b1;
         bus.in_data  = words[idx];
         #1;
         if (bus.in_valid && bus.in_ready) begin
            if (!bus.buf_wr_en || bus.buf_wr_addr !== 4'(idx * 4) || bus.buf_wr_data !== words[idx])
               wr_bad++;
            idx++;
         end else if (bus.buf_wr_en) begin
            wr_bad++;
         end
         v = ~v;
         @(negedge clk);
      end
      if (idx < 4) timeout++;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   task automatic stream_bytes(input bit rnd, input int chg_at, input int stop_at);
      bit         stalled = 1'b0;
      addr_t      paddr   = '0;
      logic [7:0] pdata   = '0;
      got.delete();
      n_last = 0; last_bad = 0; stall_bad = 0; done_cnt = 0; done_lat = -1; gap = 0;
      first_acc = -1; last_acc = -100;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         start_i = (cyc == chg_at);
         if (cyc == chg_at) num_pass_i = 8'd7;
         if (done_o) begin
            done_cnt++;
            done_lat = cyc - last_acc;
            bus.out_ready = 1'b0;
            start_i = 1'b0;
            @(negedge clk);
            if (done_o) done_cnt++;
            return;
         end
         if (stalled && (!bus.out_valid || bus.buf_rd_addr !== paddr || rd_data !== pdata))
            stall_bad++;
         if (bus.out_valid) begin
            if (stop_at >= 0 && got.size() == stop_at) begin
               bus.out_ready = 1'b0;
               start_i = 1'b0;
               return;
            end
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_last !== ((got.size() % 16) == 15)) last_bad++;
            if (bus.out_ready) begin
               got.push_back(rd_data);
               if (bus.out_last) n_last++;
               if (first_acc < 0) first_acc = cyc;
               last_acc = cyc;
            end
            stalled = !bus.out_ready;
            paddr   = bus.buf_rd_addr;
            pdata   = rd_data;
         end else begin
            gap++;
            bus.out_ready = 1'b0;
            stalled = 1'b0;
         end
         @(negedge clk);
      end
      start_i = 1'b0;
      timeout++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy_o, done_o, bus.in_ready, bus.out_valid, bus.out_last, bus.buf_wr_en} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b want=000000",
                  {busy_o, done_o, bus.in_ready, bus.out_valid, bus.out_last, bus.buf_wr_en});
      end
      checks++;
      if ({bus.buf_wr_addr, bus.buf_rd_addr} !== 8'h00) begin
         errors++;
         $display("FAIL reset_addr got=%h want=00", {bus.buf_wr_addr, bus.buf_rd_addr});
      end
      checks++;
      if (bus.buf_wr_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_wr_data got=%h want=0", bus.buf_wr_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_pass();
      start_job(1);
      load_words(1'b0);
      checks++;
      if (wr_bad !== 0 || timeout !== 0) begin
         errors++;
         $display("FAIL single_load wr_bad=%0d timeout=%0d want 0/0", wr_bad, timeout);
      end
      stream_bytes(1'b0, -1, -1);
      checks++;
      if (seq_errors(1) !== 0) begin
         errors++;
         $display("FAIL single_seq bad=%0d count=%0d want 0 bad of 16", seq_errors(1), got.size());
      end
      checks++;
      if (n_last !== 1 || last_bad !== 0) begin
         errors++;
         $display("FAIL single_last pulses=%0d bad=%0d want 1/0", n_last, last_bad);
      end
      checks++;
      if (last_acc - first_acc !== 15) begin
         errors++;
         $display("FAIL single_span got=%0d want 15", last_acc - first_acc);
      end
      checks++;
      if (done_cnt !== 1 || done_lat !== 1) begin
         errors++;
         $display("FAIL single_done count=%0d latency=%0d want 1/1", done_cnt, done_lat);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL single_idle busy=%b want 0", busy_o);
      end
   endtask

   task automatic test_multi_pass();
      start_job(3);
      load_words(1'b0);
      stream_bytes(1'b0, -1, -1);
      checks++;
      if (seq_errors(3) !== 0) begin
         errors++;
         $display("FAIL multi_seq bad=%0d count=%0d want 0 bad of 48", seq_errors(3), got.size());
      end
      checks++;
      if (n_last !== 3 || last_bad !== 0) begin
         errors++;
         $display("FAIL multi_last pulses=%0d bad=%0d want 3/0", n_last, last_bad);
      end
      checks++;
      if (last_acc - first_acc !== 47 || gap !== 0) begin
         errors++;
         $display("FAIL multi_span span=%0d gaps=%0d want 47/0", last_acc - first_acc, gap);
      end
      checks++;
      if (done_cnt !== 1 || done_lat !== 1) begin
         errors++;
         $display("FAIL multi_done count=%0d latency=%0d want 1/1", done_cnt, done_lat);
      end
   endtask

   task automatic test_stall();
      start_job(2);
      load_words(1'b1);
      checks++;
      if (wr_bad !== 0 || timeout !== 0) begin
         errors++;
         $display("FAIL stall_load wr_bad=%0d timeout=%0d want 0/0", wr_bad, timeout);
      end
      stream_bytes(1'b1, -1, -1);
      checks++;
      if (seq_errors(2) !== 0) begin
         errors++;
         $display("FAIL stall_seq bad=%0d count=%0d want 0 bad of 32", seq_errors(2), got.size());
      end
      checks++;
      if (stall_bad !== 0) begin
         errors++;
         $display("FAIL stall_stable got=%0d unstable cycles want 0", stall_bad);
      end
      checks++;
      if (n_last !== 2 || last_bad !== 0 || done_cnt !== 1) begin
         errors++;
         $display("FAIL stall_last pulses=%0d bad=%0d done=%0d want 2/0/1", n_last, last_bad, done_cnt);
      end
   endtask

   task automatic test_zero_pass();
      start_job(0);
      load_words(1'b0);
      checks++;
      if (wr_bad !== 0 || timeout !== 0) begin
         errors++;
         $display("FAIL zero_load wr_bad=%0d timeout=%0d want 0/0", wr_bad, timeout);
      end
      checks++;
      if ({done_o, busy_o, bus.out_valid} !== 3'b110) begin
         errors++;
         $display("FAIL zero_done got done/busy/valid=%b want 110", {done_o, busy_o, bus.out_valid});
      end
      @(negedge clk);
      checks++;
      if ({done_o, busy_o, bus.out_valid} !== 3'b000) begin
         errors++;
         $display("FAIL zero_idle got done/busy/valid=%b want 000", {done_o, busy_o, bus.out_valid});
      end
   endtask

   task automatic test_ignore_start();
      start_job(2);
      load_words(1'b0);
      stream_bytes(1'b0, 5, -1);
      checks++;
      if (seq_errors(2) !== 0) begin
         errors++;
         $display("FAIL ignore_seq bad=%0d count=%0d want 0 bad of 32", seq_errors(2), got.size());
      end
      checks++;
      if (n_last !== 2 || done_cnt !== 1) begin
         errors++;
         $display("FAIL ignore_count pulses=%0d done=%0d want 2/1", n_last, done_cnt);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL ignore_idle busy=%b want 0", busy_o);
      end
      num_pass_i = '0;
   endtask

   task automatic test_mid_reset();
      start_job(2);
      load_words(1'b0);
      stream_bytes(1'b0, -1, 7);
      checks++;
      if (got.size() !== 7 || bus.buf_rd_addr !== 4'd7) begin
         errors++;
         $display("FAIL midrst_pos bytes=%0d addr=%0d want 7/7", got.size(), bus.buf_rd_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy_o, done_o, bus.in_ready, bus.out_valid, bus.out_last, bus.buf_wr_en} !== 6'b0 ||
          bus.buf_rd_addr !== 4'd0 || bus.buf_wr_addr !== 4'd0) begin
         errors++;
         $display("FAIL midrst_idle flags=%b rd=%0d wr=%0d want 000000/0/0",
                  {busy_o, done_o, bus.in_ready, bus.out_valid, bus.out_last, bus.buf_wr_en},
                  bus.buf_rd_addr, bus.buf_wr_addr);
      end
      rst = 1'b0;
      start_job(1);
      load_words(1'b0);
      stream_bytes(1'b0, -1, -1);
      checks++;
      if (seq_errors(1) !== 0 || done_cnt !== 1) begin
         errors++;
         $display("FAIL midrst_rerun bad=%0d done=%0d want 0/1", seq_errors(1), done_cnt);
      end
   endtask

   initial begin
      words[0] = 32'h00010203;
      words[1] = 32'h04050607;
      words[2] = 32'h08090A0B;
      words[3] = 32'h0C0D0E0F;
      rst           = 1'b1;
      start_i       = 1'b0;
      num_pass_i    = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single_pass();
      test_multi_pass();
      test_stall();
      test_zero_pass();
      test_ignore_start();
      test_mid_reset();
      checks++;
      if (timeout !== 0) begin
         errors++;
         $display("FAIL timeout got=%0d want 0", timeout);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
